// File: rtl/alarm_pkg.sv
// State encodings, counter width and BCD field positions shared by the alarm sequencer.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RING   = 2'b01,
    ST_SNOOZE = 2'b10
  } alarm_state_e;

  localparam int CNT_W   = 9;
  localparam int HHMM_HI = 23;
  localparam int HHMM_LO = 8;
  localparam int SS_HI   = 7;
  localparam int SS_LO   = 0;

  // Alarm minute reached exactly at ss=00; alarm seconds never take part.
  function automatic logic alarm_match(input logic [23:0] t, input logic [15:0] a_hhmm);
    return (t[HHMM_HI:HHMM_LO] == a_hhmm) && (t[SS_HI:SS_LO] == 8'h00);
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Free-running clk-to-seconds divider: one-cycle sec_tick at wrap, phase_hi for the first half second.
module sec_prescaler #(
  parameter int CLK_HZ = 100
) (
  input  logic clk,
  input  logic rst,
  output logic sec_tick,
  output logic phase_hi
);

  localparam int            PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

  logic [PW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign sec_tick = (r_count == LAST);
  assign phase_hi = (r_count < HALF);

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm ring/snooze/dismiss sequencer feeding the buzzer enable.
// Define ALARM_BEEP_PATTERN_EN for a half-second on/off tone while ringing; otherwise the tone is steady.
module alarm_snooze_ctrl
  import alarm_pkg::*;
#(
  parameter int CLK_HZ     = 100,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] time_bcd,
  input  logic [23:0] alarm_bcd,
  input  logic        arm,
  input  logic        key_stop,
  input  logic        key_snooze,
  output logic        beepen,
  output logic [1:0]  state,
  output logic [1:0]  snooze_cnt
);

  localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SNZ_LOAD  = CNT_W'(SNOOZE_SEC);
  localparam logic [1:0]       SNZ_MAX   = 2'(MAX_SNOOZE);

  alarm_state_e     r_state;
  logic             r_beepen;
  logic [1:0]       r_snooze_cnt;
  logic [CNT_W-1:0] r_ring_cnt;
  logic [CNT_W-1:0] r_snz_cnt;
  logic             r_match_d;

  logic w_match;
  logic w_trigger;
  logic w_sec_tick;
  logic w_phase_hi;
  logic w_beep_gate;
  logic w_snooze_left;
  logic w_unused;

  sec_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_prescaler (
    .clk      (clk),
    .rst      (rst),
    .sec_tick (w_sec_tick),
    .phase_hi (w_phase_hi)
  );

  assign w_match       = alarm_match(time_bcd, alarm_bcd[HHMM_HI:HHMM_LO]);
  assign w_trigger     = w_match & ~r_match_d & arm;
  assign w_snooze_left = (r_snooze_cnt < SNZ_MAX);

`ifdef ALARM_BEEP_PATTERN_EN
  assign w_beep_gate = w_phase_hi;
  assign w_unused    = ^alarm_bcd[SS_HI:SS_LO];
`else
  assign w_beep_gate = 1'b1;
  assign w_unused    = ^{alarm_bcd[SS_HI:SS_LO], w_phase_hi};
`endif

  // Outputs are registered alongside the state, so beepen follows the state it is written with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_beepen     <= 1'b0;
      r_snooze_cnt <= 2'd0;
      r_ring_cnt   <= '0;
      r_snz_cnt    <= '0;
      r_match_d    <= 1'b0;
    end else begin
      r_match_d <= w_match;
      if (!arm) begin
        r_state      <= ST_IDLE;
        r_beepen     <= 1'b0;
        r_snooze_cnt <= 2'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_trigger) begin
              r_state      <= ST_RING;
              r_ring_cnt   <= RING_LOAD;
              r_snooze_cnt <= 2'd0;
              r_beepen     <= w_beep_gate;
            end else begin
              r_beepen <= 1'b0;
            end
          end
          ST_RING: begin
            if (key_stop) begin
              r_state      <= ST_IDLE;
              r_beepen     <= 1'b0;
              r_snooze_cnt <= 2'd0;
            end else if (key_snooze || (r_ring_cnt == '0)) begin
              // Manual snooze and unattended timeout share one path, including exhaustion.
              if (w_snooze_left) begin
                r_state      <= ST_SNOOZE;
                r_snz_cnt    <= SNZ_LOAD;
                r_snooze_cnt <= r_snooze_cnt + 2'd1;
                r_beepen     <= 1'b0;
              end else begin
                r_state      <= ST_IDLE;
                r_beepen     <= 1'b0;
                r_snooze_cnt <= 2'd0;
              end
            end else begin
              r_beepen <= w_beep_gate;
              if (w_sec_tick) begin
                r_ring_cnt <= r_ring_cnt - 1'b1;
              end
            end
          end
          ST_SNOOZE: begin
            if (key_stop) begin
              r_state      <= ST_IDLE;
              r_beepen     <= 1'b0;
              r_snooze_cnt <= 2'd0;
            end else if (r_snz_cnt == '0) begin
              r_state    <= ST_RING;
              r_ring_cnt <= RING_LOAD;
              r_beepen   <= w_beep_gate;
            end else begin
              r_beepen <= 1'b0;
              if (w_sec_tick) begin
                r_snz_cnt <= r_snz_cnt - 1'b1;
              end
            end
          end
          default: begin
            r_state      <= ST_IDLE;
            r_beepen     <= 1'b0;
            r_snooze_cnt <= 2'd0;
          end
        endcase
      end
    end
  end

  assign beepen     = r_beepen;
  assign state      = r_state;
  assign snooze_cnt = r_snooze_cnt;

endmodule
